input_buffer: RTL and testbench

- Front-end word buffer for the Viterbi decoder.
- Accepts 16-bit received code words on data_in and holds the word currently being decoded (the "active" word).
- Presents the active word as eight 2-bit symbol pairs to the branch-metric logic.
- Queues words that arrive while decoding is in progress; the decoder pulses refresh when it has finished the active word.

---
 rtl/input_buffer.sv | 97 +++++++++
 tb/tb_input_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/input_buffer.sv
// Front-end word buffer for the Viterbi decoder: holds the active code word,
// queues words that arrive while it is being decoded, and splits it into symbol pairs.
module input_buffer #(
    parameter int unsigned FIFO_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        refresh,
    input  logic [15:0] data_in,
    output logic [1:0]  bit_pair_0,
    output logic [1:0]  bit_pair_1,
    output logic [1:0]  bit_pair_2,
    output logic [1:0]  bit_pair_3,
    output logic [1:0]  bit_pair_4,
    output logic [1:0]  bit_pair_5,
    output logic [1:0]  bit_pair_6,
    output logic [1:0]  bit_pair_7
);

    // Pointers need at least one bit even when the queue holds a single entry.
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [15:0]      active_word;
    logic             active_valid;
    logic [15:0]      prev_in;
    logic [15:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic offered;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic bypass;
    logic push;
    logic go_idle;

    always_comb begin
        offered    = (data_in != prev_in);
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        pop        = refresh && !fifo_empty;
        bypass     = !pop && offered && (refresh || !active_valid);
        // A pop in the same cycle frees a slot, so a full queue can still take the word.
        push       = offered && !bypass && (!fifo_full || pop);
        go_idle    = refresh && fifo_empty && !offered;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_word  <= '0;
            active_valid <= 1'b0;
            prev_in      <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else begin
            prev_in <= data_in;
            if (pop) begin
                active_word  <= fifo_mem[rd_ptr];
                active_valid <= 1'b1;
                rd_ptr       <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end else if (bypass) begin
                active_word  <= data_in;
                active_valid <= 1'b1;
            end else if (go_idle) begin
                active_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[wr_ptr] <= data_in;
        end
    end

    assign bit_pair_0 = active_word[1:0];
    assign bit_pair_1 = active_word[3:2];
    assign bit_pair_2 = active_word[5:4];
    assign bit_pair_3 = active_word[7:6];
    assign bit_pair_4 = active_word[9:8];
    assign bit_pair_5 = active_word[11:10];
    assign bit_pair_6 = active_word[13:12];
    assign bit_pair_7 = active_word[15:14];

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: directed walk-through plus randomized traffic, checked
// against a shifting-array queue model for a depth-1 and a depth-3 instance.
module tb_input_buffer;

    logic        clk;
    logic        rst;
    logic        refresh;
    logic [15:0] data_in;
    logic [1:0]  a0, a1, a2, a3, a4, a5, a6, a7;
    logic [1:0]  b0, b1, b2, b3, b4, b5, b6, b7;

    int unsigned total;
    int unsigned bad;

    logic [15:0]  m_active [2];
    logic         m_valid  [2];
    logic [15:0]  m_prev   [2];
    logic [15:0]  m_fifo   [2][4];
    int unsigned  m_cnt    [2];

    input_buffer #(.FIFO_DEPTH(1)) dut0 (
        .clk(clk), .rst(rst), .refresh(refresh), .data_in(data_in),
        .bit_pair_0(a0), .bit_pair_1(a1), .bit_pair_2(a2), .bit_pair_3(a3),
        .bit_pair_4(a4), .bit_pair_5(a5), .bit_pair_6(a6), .bit_pair_7(a7)
    );

    input_buffer #(.FIFO_DEPTH(3)) dut1 (
        .clk(clk), .rst(rst), .refresh(refresh), .data_in(data_in),
        .bit_pair_0(b0), .bit_pair_1(b1), .bit_pair_2(b2), .bit_pair_3(b3),
        .bit_pair_4(b4), .bit_pair_5(b5), .bit_pair_6(b6), .bit_pair_7(b7)
    );

    wire [15:0] out0 = {a7, a6, a5, a4, a3, a2, a1, a0};
    wire [15:0] out1 = {b7, b6, b5, b4, b3, b2, b1, b0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = '0;
            m_valid[k]  = 1'b0;
            m_prev[k]   = '0;
            m_cnt[k]    = 0;
        end
    endtask

    task automatic model_edge(input int k, input logic [15:0] d, input logic r);
        int unsigned depth;
        logic        fresh;
        depth = (k == 0) ? 1 : 3;
        fresh = (d != m_prev[k]);
        if (r && m_cnt[k] > 0) begin
            m_active[k] = m_fifo[k][0];
            for (int i = 0; i < 3; i++) m_fifo[k][i] = m_fifo[k][i+1];
            m_cnt[k]--;
            m_valid[k] = 1'b1;
            if (fresh) begin
                m_fifo[k][m_cnt[k]] = d;
                m_cnt[k]++;
            end
        end else if (fresh && (r || !m_valid[k])) begin
            m_active[k] = d;
            m_valid[k]  = 1'b1;
        end else if (r) begin
            m_valid[k] = 1'b0;
        end else if (fresh && m_cnt[k] < depth) begin
            m_fifo[k][m_cnt[k]] = d;
            m_cnt[k]++;
        end
        m_prev[k] = d;
    endtask

    task automatic check_models(input string tag);
        check({tag, "/d1"}, out0, m_active[0]);
        check({tag, "/d3"}, out1, m_active[1]);
    endtask

    // One clock: drive, model the edge, sample 1 time unit after it.
    task automatic step(input logic [15:0] d, input logic r, input logic rs, input string tag);
        data_in = d;
        refresh = r;
        rst     = rs;
        @(posedge clk);
        if (rs) model_reset();
        else begin
            model_edge(0, d, r);
            model_edge(1, d, r);
        end
        #1;
        check_models(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst     = 1'b1;
        data_in = '0;
        refresh = 1'b0;
        model_reset();
        #1;
        check({tag, "_async0"}, out0, 16'h0000);
        check({tag, "_async1"}, out1, 16'h0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        model_reset();
        rst = 1'b1; refresh = 1'b0; data_in = '0;

        step(16'h0000, 1'b0, 1'b1, "rst_a");
        step(16'h0000, 1'b0, 1'b1, "rst_b");
        check("rst_out", out0, 16'h0000);
        step(16'h0000, 1'b0, 1'b0, "rel");
        check("rel_out", out0, 16'h0000);

        step(16'hA5A5, 1'b0, 1'b0, "load");
        check("load_out", out0, 16'hA5A5);
        step(16'h5A5A, 1'b0, 1'b0, "queue");
        check("queue_hold", out0, 16'hA5A5);
        step(16'h5A5A, 1'b1, 1'b0, "pop");
        check("pop_out", out0, 16'h5A5A);
        step(16'h5A5A, 1'b0, 1'b0, "hold1");
        step(16'h5A5A, 1'b0, 1'b0, "hold2");
        check("no_requeue", out0, 16'h5A5A);

        step(16'hFFFF, 1'b0, 1'b0, "fill");
        step(16'h0000, 1'b0, 1'b0, "drop");
        check("drop_hold", out0, 16'h5A5A);
        step(16'h0000, 1'b1, 1'b0, "pop_ff");
        check("pop_ffff", out0, 16'hFFFF);
        step(16'h0000, 1'b1, 1'b0, "idle");
        check("idle_hold", out0, 16'hFFFF);

        step(16'h1234, 1'b0, 1'b0, "sim_a");
        check("idle_bypass", out0, 16'h1234);
        step(16'hBEEF, 1'b0, 1'b0, "sim_b");
        step(16'hC0DE, 1'b1, 1'b0, "sim_c");
        check("sim_pop", out0, 16'hBEEF);
        step(16'hC0DE, 1'b1, 1'b0, "sim_d");
        check("sim_next", out0, 16'hC0DE);

        step(16'h1111, 1'b0, 1'b0, "pre_rst");
        async_reset("mid");
        step(16'h0000, 1'b0, 1'b1, "mid_hold");
        step(16'h0000, 1'b1, 1'b0, "post_a");
        step(16'h0000, 1'b1, 1'b0, "post_b");
        check("post_noload", out0, 16'h0000);
        step(16'h7777, 1'b0, 1'b0, "post_new");
        check("post_load", out0, 16'h7777);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] d;
            logic        r;
            if ($urandom_range(0, 99) == 0) begin
                async_reset("rnd");
                step(16'h0000, 1'b0, 1'b1, "rnd_rst");
            end else begin
                case ($urandom_range(0, 3))
                    0, 1:    d = data_in;
                    2:       d = 16'(($urandom_range(0, 3)) * 16'h1111);
                    default: d = 16'($urandom);
                endcase
                r = ($urandom_range(0, 2) == 0);
                step(d, r, 1'b0, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
